// File: rtl/spi_slave_word.sv
// SPI slave with word-level valid/ready TX and RX interfaces.
// All SPI pins are oversampled on sysClk. Edge strobes are derived from the
// synchronised SCLK, so every SPI action takes effect a few sysClk cycles
// after the pin edge. The master must leave enough sysClk cycles between edges.
module spi_slave_word #(
    parameter int               WIDTH     = 8,
    parameter int               CPOL      = 0,
    parameter int               CPHA      = 0,
    parameter int               MSB_FIRST = 1,
    parameter logic [WIDTH-1:0] FILL      = '1
) (
    input  logic             sysClk,
    input  logic             reset_n,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe_o,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST      = CW'(WIDTH - 1);
    localparam logic           SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state, state_next;
    logic             sclk_s1, sclk_s2, sclk_h;
    logic             cs_s1, cs_s2, cs_h;
    logic             mosi_s1, mosi_s2, mosi_h;
    logic             sclk_rise, sclk_fall, lead, trail;
    logic             sample_edge, shift_edge, cs_fall, cs_rise;
    logic             load_evt, word_done, reload_pend;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_sh, rx_sh, rx_next, load_word, hold_data;
    logic             hold_full;

    // Bit currently at the wire end of a TX word for the configured order.
    function automatic logic front(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the wire-end bit so the next one moves to the front.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Two-flop synchronisers plus a history flop. They are preset to idle levels
    // so that leaving reset never produces a false SCLK or CS edge.
    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            {sclk_s1, sclk_s2, sclk_h} <= {3{SCLK_IDLE}};
            {cs_s1, cs_s2, cs_h}       <= 3'b111;
            {mosi_s1, mosi_s2, mosi_h} <= 3'b000;
        end else begin
            {sclk_s1, sclk_s2, sclk_h} <= {sclk_i, sclk_s1, sclk_s2};
            {cs_s1, cs_s2, cs_h}       <= {cs_n_i, cs_s1, cs_s2};
            {mosi_s1, mosi_s2, mosi_h} <= {mosi_i, mosi_s1, mosi_s2};
        end
    end

    assign sclk_rise   = sclk_s2 & ~sclk_h;
    assign sclk_fall   = ~sclk_s2 & sclk_h;
    assign lead        = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail       = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail : lead;
    assign shift_edge  = (CPHA != 0) ? lead : trail;
    assign cs_fall     = cs_h & ~cs_s2;
    assign cs_rise     = ~cs_h & cs_s2;
    assign busy        = ~cs_s2;
    assign tx_ready    = ~hold_full;

    // mosi_h has the same age as sclk_h, so it holds the bit that was present at the edge.
    assign rx_next = (MSB_FIRST != 0) ? {rx_sh[WIDTH-2:0], mosi_h} : {mosi_h, rx_sh[WIDTH-1:1]};

    // A word accepted in the same cycle as a load goes straight to the shifter.
    assign load_word = hold_full ? hold_data : (tx_valid ? tx_data : FILL);

    // State register.
    always_ff @(posedge sysClk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state, word-load and word-complete strobes. A CS rise overrides everything.
    always_comb begin
        state_next = state;
        load_evt   = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE:  if (cs_fall) state_next = LOAD;
            LOAD:  begin
                load_evt   = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                word_done = sample_edge && (bit_cnt == LAST);
                load_evt  = (CPHA == 0) ? word_done : (shift_edge && reload_pend);
            end
            default: state_next = IDLE;
        endcase
        if (cs_rise) begin
            state_next = IDLE;
            load_evt   = 1'b0;
            word_done  = 1'b0;
        end
    end

    // TX holding register and underrun pulse.
    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            hold_full   <= 1'b0;
            hold_data   <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load_evt & ~hold_full & ~tx_valid;
            if (load_evt)
                hold_full <= 1'b0;
            else if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Shifters, bit counter and MISO. tx_sh always holds the next bit to drive at its front.
    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            miso_o      <= 1'b0;
            miso_oe_o   <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else if (cs_rise) begin
            miso_o      <= 1'b0;
            miso_oe_o   <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else if (state == LOAD) begin
            miso_oe_o   <= 1'b1;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            if (CPHA == 0) begin
                miso_o <= front(load_word);
                tx_sh  <= advance(load_word);
            end else begin
                tx_sh  <= load_word;
            end
        end else if (state == SHIFT) begin
            if (shift_edge) begin
                if (load_evt) begin
                    miso_o      <= front(load_word);
                    tx_sh       <= advance(load_word);
                    reload_pend <= 1'b0;
                end else begin
                    miso_o <= front(tx_sh);
                    tx_sh  <= advance(tx_sh);
                end
            end
            if (sample_edge) begin
                rx_sh <= rx_next;
                if (word_done) begin
                    bit_cnt <= '0;
                    if (CPHA == 0) tx_sh <= load_word;
                    else           reload_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // RX word output with hold-until-ready. A completion overwrites any unread word.
    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: four 8-bit instances (modes 0..3) and one 16-bit LSB-first instance.
// A bit-banged master drives one instance at a time. Expected RX words go into a queue,
// and a monitor pops them on every rx_valid&rx_ready handshake.
`timescale 1ns/1ps
module tb_spi_slave_word;

    localparam int HALF = 80;
    localparam int W_T[5]    = '{8, 8, 8, 8, 16};
    localparam int CPOL_T[5] = '{0, 0, 1, 1, 0};
    localparam int CPHA_T[5] = '{0, 1, 0, 1, 0};
    localparam int MSB_T[5]  = '{1, 1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  sclk, cs_n, tx_valid, tx_ready, miso, oe, rx_valid, rx_overrun, tx_underrun, busy;
    logic        mosi;
    logic        rx_ready;
    logic [31:0] tx_data;
    logic [7:0]  rx_d8 [4];
    logic [15:0] rx_d16;
    logic [2:0]  sel;
    logic [31:0] cur_rx;
    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          un_cnt = 0;
    int          ov_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_w8
        spi_slave_word #(.WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1)) u_dut (
            .sysClk(clk), .reset_n(reset_n), .sclk_i(sclk[g]), .cs_n_i(cs_n[g]), .mosi_i(mosi),
            .miso_o(miso[g]), .miso_oe_o(oe[g]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_d8[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready),
            .rx_overrun(rx_overrun[g]), .tx_underrun(tx_underrun[g]), .busy(busy[g]));
    end

    spi_slave_word #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_w16 (
        .sysClk(clk), .reset_n(reset_n), .sclk_i(sclk[4]), .cs_n_i(cs_n[4]), .mosi_i(mosi),
        .miso_o(miso[4]), .miso_oe_o(oe[4]), .tx_data(tx_data[15:0]), .tx_valid(tx_valid[4]),
        .tx_ready(tx_ready[4]), .rx_data(rx_d16), .rx_valid(rx_valid[4]), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun[4]), .tx_underrun(tx_underrun[4]), .busy(busy[4]));

    always_comb cur_rx = (sel == 3'd4) ? {16'h0, rx_d16} : {24'h0, rx_d8[sel[1:0]]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor and pulse counters for the selected instance.
    always @(negedge clk) begin
        if (reset_n && rx_valid[sel] && rx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_unexpected got=%h want=none at %0t", cur_rx, $time);
            end else begin
                chk("rx_data", cur_rx, exp_q.pop_front());
            end
        end
        if (tx_underrun[sel]) un_cnt++;
        if (rx_overrun[sel])  ov_cnt++;
    end

    task automatic preload(input int id, input logic [31:0] d);
        @(negedge clk);
        chk("tx_ready_empty", 32'(tx_ready[id]), 32'd1);
        tx_data = d;
        tx_valid[id] = 1'b1;
        @(negedge clk);
        tx_valid[id] = 1'b0;
        chk("tx_ready_full", 32'(tx_ready[id]), 32'd0);
    endtask

    task automatic cs_low(input int id);
        sel = 3'(id);
        cs_n[id] = 1'b0;
        #HALF;
    endtask

    task automatic cs_high(input int id);
        #HALF;
        cs_n[id] = 1'b1;
        #(2 * HALF);
    endtask

    // Shift n bits; got[] collects MISO in the same bit positions as the slave's word.
    task automatic bits(input int id, input logic [31:0] word, input int n, output logic [31:0] got);
        int   b;
        logic pol;
        pol = (CPOL_T[id] != 0);
        got = '0;
        for (int i = 0; i < n; i++) begin
            b = (MSB_T[id] != 0) ? W_T[id] - 1 - i : i;
            if (CPHA_T[id] == 0) begin
                mosi = word[b];
                #HALF;
                got[b] = miso[id];
                sclk[id] = ~pol;
                #HALF;
                sclk[id] = pol;
            end else begin
                sclk[id] = ~pol;
                mosi = word[b];
                #HALF;
                got[b] = miso[id];
                sclk[id] = pol;
                #HALF;
            end
        end
    endtask

    task automatic one_word(input int id, input logic [31:0] txw, input logic [31:0] mw);
        logic [31:0] got;
        preload(id, txw);
        exp_q.push_back(mw);
        cs_low(id);
        bits(id, mw, W_T[id], got);
        chk("miso_oe_active", 32'(oe[id]), 32'd1);
        cs_high(id);
        chk("miso_word", got, txw);
        chk("idle_oe_miso", {30'h0, oe[id], miso[id]}, 32'd0);
    endtask

    initial begin
        logic [31:0] g1, g2;
        reset_n = 1'b0; cs_n = '1; tx_valid = '0; mosi = 1'b0; rx_ready = 1'b1;
        tx_data = '0; sel = 3'd0;
        sclk = 5'b01100;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("rst_flags", 32'({miso[i], oe[i], tx_ready[i], rx_valid[i], busy[i], rx_overrun[i], tx_underrun[i]}), 32'h10);
            chk("rst_rx_data", (i == 4) ? {16'h0, rx_d16} : {24'h0, rx_d8[i]}, 32'h0);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // All four modes, 8-bit MSB-first.
        for (int id = 0; id < 4; id++) one_word(id, 32'hA5, 32'h3C);
        // 16-bit LSB-first.
        one_word(4, 32'h1234, 32'hBEEF);

        // Back-to-back words on mode 1. The second word finds an empty holding register.
        preload(1, 32'h5A);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        un_cnt = 0;
        cs_low(1);
        bits(1, 32'h11, 8, g1);
        bits(1, 32'h22, 8, g2);
        cs_high(1);
        chk("b2b_miso_w1", g1, 32'h5A);
        chk("b2b_miso_fill", g2, 32'hFF);
        chk("underrun_pulses", 32'(un_cnt), 32'd1);

        // Overrun: rx_ready held low across two words, so the second word wins.
        rx_ready = 1'b0;
        ov_cnt = 0;
        exp_q.push_back(32'h7E);
        cs_low(0);
        bits(0, 32'h81, 8, g1);
        bits(0, 32'h7E, 8, g2);
        cs_high(0);
        chk("overrun_pulses", 32'(ov_cnt), 32'd1);
        chk("rx_valid_held", 32'(rx_valid[0]), 32'd1);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rx_valid_drained", 32'(rx_valid[0]), 32'd0);

        // CS abort after 5 bits: no word and MISO released. The next transfer still works.
        cs_low(0);
        bits(0, 32'hFF, 5, g1);
        chk("abort_busy", 32'(busy[0]), 32'd1);
        cs_high(0);
        chk("abort_state", 32'({oe[0], miso[0], rx_valid[0], busy[0]}), 32'd0);
        one_word(0, 32'hC3, 32'h96);

        // Reset in the middle of a word.
        cs_low(0);
        bits(0, 32'h55, 4, g1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_flags", 32'({miso[0], oe[0], tx_ready[0], rx_valid[0], busy[0]}), 32'h04);
        cs_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        one_word(0, 32'h3C, 32'hA5);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
